// File: rtl/counter_pkg.sv
// Shared types and helpers for the bounded step counter family.
package counter_pkg;

  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} count_mode_e;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;

  // Highest value actually reachable from MIN_VAL in whole steps.
  function automatic int unsigned calc_last(input int unsigned min_val,
                                            input int unsigned max_val,
                                            input int unsigned step);
    return min_val + ((max_val - min_val) / step) * step;
  endfunction

endpackage

// File: rtl/bounded_step_next.sv
// Combinational next-value, boundary and load-validity logic for the counter.
module bounded_step_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 30,
  parameter int unsigned STEP    = 2
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_hit,
  output logic             load_valid
);

  localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(calc_last(MIN_VAL, MAX_VAL, STEP));

  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   data_w;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   load_off;
  logic [WIDTH-1:0] down_diff;
  logic             up_ok;
  logic             down_ok;
  logic             wrap;

  // One extra bit keeps count+STEP from overflowing before the bound check.
  always_comb begin
    count_w      = {1'b0, count};
    data_w       = {1'b0, data_in};
    up_sum       = count_w + STEP_W;
    down_diff    = count - STEP_W[WIDTH-1:0];
    up_ok        = (up_sum <= MAX_W);
    down_ok      = (count_w >= MIN_W + STEP_W);
    wrap         = (count_mode_e'(mode) == MODE_WRAP);
    next_count   = count;
    boundary_hit = 1'b0;

    if (count_dir_e'(up_dn) == DIR_UP) begin
      if (up_ok) begin
        next_count = up_sum[WIDTH-1:0];
      end else begin
        boundary_hit = 1'b1;
        if (wrap) next_count = MIN_W[WIDTH-1:0];
      end
    end else begin
      if (down_ok) begin
        next_count = down_diff;
      end else begin
        boundary_hit = 1'b1;
        if (wrap) next_count = LAST_W[WIDTH-1:0];
      end
    end

    // data_w+1 > MIN_W is data_w >= MIN_W without a constant compare when MIN_VAL is 0.
    load_off   = data_w - MIN_W;
    load_valid = (data_w + 1'b1 > MIN_W) && (data_w <= MAX_W) &&
                 (load_off % STEP_W == '0);
  end

endmodule

// File: rtl/bounded_step_counter.sv
// Up/down counter between programmable bounds with wrap/saturate, validated load and error flag.
module bounded_step_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 30,
  parameter int unsigned STEP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             load_err,
  output logic             err_flag
);

  localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_VAL);

  if (MIN_VAL >= MAX_VAL) begin : g_bad_range
    $error("bounded_step_counter: MIN_VAL must be below MAX_VAL");
  end
  if (STEP < 1 || STEP > MAX_VAL - MIN_VAL) begin : g_bad_step
    $error("bounded_step_counter: STEP must lie in 1..MAX_VAL-MIN_VAL");
  end
  if ((MAX_VAL >> WIDTH) != 0) begin : g_bad_width
    $error("bounded_step_counter: MAX_VAL does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] next_count;
  logic             boundary_hit;
  logic             load_valid;

  bounded_step_next #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL),
    .STEP   (STEP)
  ) u_next (
    .count       (count),
    .up_dn       (up_dn),
    .mode        (mode),
    .data_in     (data_in),
    .next_count  (next_count),
    .boundary_hit(boundary_hit),
    .load_valid  (load_valid)
  );

  // Priority rst > load > en; a rejected load setting err_flag beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= MIN_CNT;
      tc       <= 1'b0;
      load_err <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_valid) begin
          count <= data_in;
        end else begin
          count    <= MIN_CNT;
          load_err <= 1'b1;
        end
      end else if (en) begin
        count <= next_count;
        tc    <= boundary_hit;
      end
      if (load && !load_valid) err_flag <= 1'b1;
      else if (clr_err)        err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bounded_step_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream and an arithmetic model.
module tb_bounded_step_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [4:0] data_in = '0;
  logic       clr_err = 1'b0;

  logic [4:0] cnt0, cnt1, cnt2;
  logic       tc0, tc1, tc2;
  logic       le0, le1, le2;
  logic       ef0, ef1, ef2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bounded_step_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(30), .STEP(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .data_in(data_in), .clr_err(clr_err),
    .count(cnt0), .tc(tc0), .load_err(le0), .err_flag(ef0));

  bounded_step_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(12), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .data_in(data_in), .clr_err(clr_err),
    .count(cnt1), .tc(tc1), .load_err(le1), .err_flag(ef1));

  bounded_step_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(30), .STEP(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .data_in(data_in), .clr_err(clr_err),
    .count(cnt2), .tc(tc2), .load_err(le2), .err_flag(ef2));

  typedef struct {
    int count;
    bit tc;
    bit load_err;
    bit err_flag;
  } model_t;

  model_t mdl[3];
  int     mnv[3] = '{0, 1, 0};
  int     mxv[3] = '{30, 12, 30};
  int     stv[3] = '{2, 1, 4};

  typedef struct {
    logic       rst, en, up_dn, mode, load;
    logic [4:0] data;
    logic       clr;
    int         exp_count;
    logic       exp_tc, exp_lerr, exp_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model straight from the counting rules, using plain integers.
  function automatic model_t modelStep(model_t s, int mn, int mx, int st,
                                       bit r, bit e, bit u, bit m, bit l,
                                       int d, bit c);
    model_t n;
    bit     valid;
    int     last;
    n = s;
    if (r) begin
      n.count = mn; n.tc = 0; n.load_err = 0; n.err_flag = 0;
      return n;
    end
    n.tc = 0;
    n.load_err = 0;
    last  = mn + ((mx - mn) / st) * st;
    valid = (d >= mn) && (d <= mx) && (((d - mn) % st) == 0);
    if (l) begin
      if (valid) n.count = d;
      else begin n.count = mn; n.load_err = 1; end
    end else if (e) begin
      if (u) begin
        if (s.count + st <= mx) n.count = s.count + st;
        else begin n.tc = 1; if (!m) n.count = mn; end
      end else begin
        if (s.count - st >= mn) n.count = s.count - st;
        else begin n.tc = 1; if (!m) n.count = last; end
      end
    end
    if (l && !valid) n.err_flag = 1;
    else if (c)      n.err_flag = 0;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input int i, input logic [4:0] c, input logic t,
                          input logic le, input logic ef);
    checkOutput($sformatf("d%0d.count", i), 32'(c), 32'(mdl[i].count));
    checkOutput($sformatf("d%0d.tc", i), 32'(t), 32'(mdl[i].tc));
    checkOutput($sformatf("d%0d.load_err", i), 32'(le), 32'(mdl[i].load_err));
    checkOutput($sformatf("d%0d.err_flag", i), 32'(ef), 32'(mdl[i].err_flag));
  endtask

  // Drive one cycle of inputs, advance the models at the edge, compare just after it.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic m, input logic l,
                               input logic [4:0] d, input logic c);
    @(negedge clk);
    rst = r; en = e; up_dn = u; mode = m; load = l; data_in = d; clr_err = c;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      mdl[i] = modelStep(mdl[i], mnv[i], mxv[i], stv[i], r, e, u, m, l, int'(d), c);
    #1;
    checkDut(0, cnt0, tc0, le0, ef0);
    checkDut(1, cnt1, tc1, le1, ef1);
    checkDut(2, cnt2, tc2, le2, ef2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mdl[i] = '{mnv[i], 1'b0, 1'b0, 1'b0};

    // rst en up mode load data clr | count tc lerr err  (config 0..30 step 2)
    vecs.push_back('{1, 0, 0, 0, 0, 5'd0,  0,  0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 5'd0,  0,  2, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 5'd28, 0, 28, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 5'd0,  0, 30, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 5'd0,  0,  0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 5'd0,  0, 30, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 5'd15, 0,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 5'd0,  0,  0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 5'd31, 1,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 5'd0,  1,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 5'd30, 0, 30, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 5'd0,  0, 30, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 5'd0,  0, 30, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 5'd0,  0, 28, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 1, 5'd8,  0,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 5'd8,  0,  8, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 5'd0,  0, 10, 0, 0, 0});

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].up_dn, vecs[k].mode,
                    vecs[k].load, vecs[k].data, vecs[k].clr);
      checkOutput($sformatf("vec%0d.count", k), 32'(cnt0), 32'(vecs[k].exp_count));
      checkOutput($sformatf("vec%0d.tc", k), 32'(tc0), 32'(vecs[k].exp_tc));
      checkOutput($sformatf("vec%0d.load_err", k), 32'(le0), 32'(vecs[k].exp_lerr));
      checkOutput($sformatf("vec%0d.err_flag", k), 32'(ef0), 32'(vecs[k].exp_err));
    end

    // Full wrap period from reset: 2,4,..,30 then 0 with a single tc.
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 5'd0, 0);
      checkOutput($sformatf("wrap%0d.count", k), 32'(cnt0), 32'((2 * k) % 32));
      checkOutput($sformatf("wrap%0d.tc", k), 32'(tc0), 32'(k == 16));
    end

    // Down-wrap from the bottom: month counter to 12, step-4 counter to LAST=28.
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 0);
    applyStimulus(0, 1, 0, 0, 0, 5'd0, 0);
    checkOutput("month.count", 32'(cnt1), 32'd12);
    checkOutput("month.tc", 32'(tc1), 32'd1);
    checkOutput("step4.count", 32'(cnt2), 32'd28);
    checkOutput("step4.tc", 32'(tc2), 32'd1);

    // Saturate at the top, then run down and saturate at the bottom.
    applyStimulus(0, 0, 0, 0, 1, 5'd28, 0);
    applyStimulus(0, 1, 1, 1, 0, 5'd0, 0);
    checkOutput("sat_up.count", 32'(cnt0), 32'd30);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 1, 0, 5'd0, 0);
      checkOutput("sat_hold_hi.count", 32'(cnt0), 32'd30);
      checkOutput("sat_hold_hi.tc", 32'(tc0), 32'd1);
    end
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 1, 0, 1, 0, 5'd0, 0);
      checkOutput($sformatf("sat_dn%0d.count", k), 32'(cnt0), 32'(30 - 2 * k));
    end
    applyStimulus(0, 1, 0, 1, 0, 5'd0, 0);
    checkOutput("sat_hold_lo.count", 32'(cnt0), 32'd0);
    checkOutput("sat_hold_lo.tc", 32'(tc0), 32'd1);

    // Reset mid-count with en and load both asserted, then a long idle hold.
    applyStimulus(0, 0, 0, 0, 1, 5'd18, 1);
    applyStimulus(0, 0, 0, 0, 1, 5'd15, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd18, 0);
    applyStimulus(1, 1, 1, 0, 1, 5'd18, 0);
    checkOutput("rst_mid.count", 32'(cnt0), 32'd0);
    checkOutput("rst_mid.err_flag", 32'(ef0), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd18, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, k[0], k[1], 0, 5'($urandom_range(0, 31)), 0);
      checkOutput("idle.count", 32'(cnt0), 32'd18);
      checkOutput("idle.tc", 32'(tc0), 32'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 7) == 0),
                    5'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
